// File: rtl/la_chainctrl.sv
// la_chainctrl: loads a parallel word LSB-first into an external flop chain and returns the chain's previous contents.
// Latency: accept edge T -> chain_en T+1..T+DW, update T+DW+1, out_valid T+DW+2; one transaction per DW+3 cycles at best.
// Backpressure: in_ready is high only in IDLE; the readback word is held in DONE until out_ready.
//
// Ports:
//   clk, nreset                   clock and synchronous active-low reset
//   in_valid/in_ready/in_data     write request handshake (word to load into the chain)
//   chain_en/chain_d/chain_q      shift enable, serial data into flop 0, serial data from flop DW-1
//   update                        one-cycle strobe after the last shift
//   out_valid/out_ready/out_data  readback handshake (previous chain contents)
//   busy                          high in any state other than IDLE
module la_chainctrl #(
    parameter int DW   = 32,
    parameter     PROP = "DEFAULT"
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          chain_en,
    output logic          chain_d,
    input  logic          chain_q,
    output logic          update,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] sreg;
    logic [CW-1:0] cnt;
    logic          cnt_last;

    assign cnt_last = (cnt == CW'(DW - 1));

    // State register plus datapath. The shift register doubles as the
    // capture register: the chain tail enters at the MSB, so after DW
    // shifts bit k holds the old content of flop DW-1-k.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg <= in_data;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    sreg <= {chain_q, sreg[DW-1:1]};
                    // Hold at the terminal count rather than wrapping.
                    if (!cnt_last) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        chain_en  = 1'b0;
        chain_d   = 1'b0;
        update    = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                chain_en = 1'b1;
                chain_d  = sreg[0];
                if (cnt_last) begin
                    state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                update    = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = sreg;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_la_chainctrl.sv
module tb_la_chainctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nreset;

    // DW=8 instance
    logic       in_valid8, in_ready8, chain_en8, chain_d8, chain_q8;
    logic       update8, out_valid8, out_ready8, busy8;
    logic [7:0] in_data8, out_data8;
    logic [7:0] chain8 = 8'h00;   // chain8[j] is flop j; flop 0 is fed by chain_d

    // DW=2 instance
    logic       in_valid2, in_ready2, chain_en2, chain_d2, chain_q2;
    logic       update2, out_valid2, out_ready2, busy2;
    logic [1:0] in_data2, out_data2;
    logic [1:0] chain2 = 2'b00;

    la_chainctrl #(.DW(8), .PROP("DEFAULT")) u8 (
        .clk(clk), .nreset(nreset),
        .in_valid(in_valid8), .in_data(in_data8), .in_ready(in_ready8),
        .chain_en(chain_en8), .chain_d(chain_d8), .chain_q(chain_q8),
        .update(update8), .out_valid(out_valid8), .out_data(out_data8),
        .out_ready(out_ready8), .busy(busy8)
    );

    la_chainctrl #(.DW(2), .PROP("DEFAULT")) u2 (
        .clk(clk), .nreset(nreset),
        .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .chain_en(chain_en2), .chain_d(chain_d2), .chain_q(chain_q2),
        .update(update2), .out_valid(out_valid2), .out_data(out_data2),
        .out_ready(out_ready2), .busy(busy2)
    );

    // External flop chains: not reset, shift whenever enabled.
    always @(posedge clk) if (chain_en8) chain8 <= {chain8[6:0], chain_d8};
    always @(posedge clk) if (chain_en2) chain2 <= {chain2[0], chain_d2};
    assign chain_q8 = chain8[7];
    assign chain_q2 = chain2[1];

    int n_checks = 0;
    int n_fail   = 0;

    logic       bq8[$];   // expected chain_d bits, DW=8
    logic [7:0] rq8[$];   // expected readback words, DW=8
    logic       bq2[$];
    logic [1:0] rq2[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors sample 1 time unit after the falling edge, seeing exactly
    // what the next rising edge will act on.
    always @(negedge clk) begin
        #1;
        if (nreset && chain_en8) begin
            if (bq8.size() == 0) check("chain_d8 unexpected", 32'd1, 32'd0);
            else check("chain_d8 bit", 32'(chain_d8), 32'(bq8.pop_front()));
        end
        if (nreset && out_valid8 && out_ready8) begin
            if (rq8.size() == 0) check("readback8 unexpected", 32'd1, 32'd0);
            else check("readback8", 32'(out_data8), 32'(rq8.pop_front()));
        end
        if (nreset && chain_en2) begin
            if (bq2.size() == 0) check("chain_d2 unexpected", 32'd1, 32'd0);
            else check("chain_d2 bit", 32'(chain_d2), 32'(bq2.pop_front()));
        end
        if (nreset && out_valid2 && out_ready2) begin
            if (rq2.size() == 0) check("readback2 unexpected", 32'd1, 32'd0);
            else check("readback2", 32'(out_data2), 32'(rq2.pop_front()));
        end
    end

    // One DW=8 write transaction, starting and ending at a falling edge.
    task automatic write8(input logic [7:0] d, input int hold, input bit glitch,
                          input bit abort, input bit collide);
        logic [7:0] exp_rb;
        logic [7:0] exp_chain;
        for (int k = 0; k < 8; k++) begin
            exp_rb[k]        = chain8[7-k];
            exp_chain[7-k]   = d[k];
            bq8.push_back(d[k]);
        end
        if (!abort) rq8.push_back(exp_rb);
        check("in_ready8 before accept", 32'(in_ready8), 32'd1);
        in_valid8 = 1'b1;
        in_data8  = d;
        @(negedge clk);                       // cycle T+1
        in_valid8 = 1'b0;
        for (int k = 0; k < 8; k++) begin     // cycles T+1..T+8
            check("chain_en8 in shift", 32'(chain_en8), 32'd1);
            check("update8 in shift", 32'(update8), 32'd0);
            if (glitch) begin
                in_valid8 = 1'b1;
                in_data8  = 8'hFF;
            end
            if (abort && k == 3) begin
                nreset = 1'b0;
                @(negedge clk);
                check("abort chain_en8", 32'(chain_en8), 32'd0);
                check("abort in_ready8", 32'(in_ready8), 32'd1);
                check("abort out_valid8", 32'(out_valid8), 32'd0);
                nreset = 1'b1;
                bq8.delete();
                for (int j = 0; j < 12; j++) begin
                    check("abort no update8", 32'(update8), 32'd0);
                    check("abort stays idle", 32'(in_ready8), 32'd1);
                    @(negedge clk);
                end
                return;
            end
            @(negedge clk);
        end
        check("update8 at T+9", 32'(update8), 32'd1);   // cycle T+9
        check("chain_en8 off in update", 32'(chain_en8), 32'd0);
        in_valid8 = 1'b0;
        @(negedge clk);                       // cycle T+10
        check("update8 one cycle", 32'(update8), 32'd0);
        check("out_valid8 at T+10", 32'(out_valid8), 32'd1);
        for (int h = 0; h < hold; h++) begin
            check("hold out_valid8", 32'(out_valid8), 32'd1);
            check("hold out_data8", 32'(out_data8), 32'(exp_rb));
            check("hold in_ready8", 32'(in_ready8), 32'd0);
            check("hold busy8", 32'(busy8), 32'd1);
            @(negedge clk);
        end
        out_ready8 = 1'b1;
        if (collide) begin
            in_valid8 = 1'b1;
            in_data8  = 8'hFF;
        end
        @(negedge clk);
        out_ready8 = 1'b0;
        in_valid8  = 1'b0;
        check("idle after handshake in_ready8", 32'(in_ready8), 32'd1);
        check("idle after handshake busy8", 32'(busy8), 32'd0);
        check("idle after handshake out_valid8", 32'(out_valid8), 32'd0);
        check("chain8 contents", 32'(chain8), 32'(exp_chain));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset = 1'b0;
        in_valid8 = 1'b0; in_data8 = 8'h00; out_ready8 = 1'b0;
        in_valid2 = 1'b0; in_data2 = 2'b00; out_ready2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready", 32'(in_ready8), 32'd1);
        check("reset chain_en", 32'(chain_en8), 32'd0);
        check("reset chain_d", 32'(chain_d8), 32'd0);
        check("reset update", 32'(update8), 32'd0);
        check("reset out_valid", 32'(out_valid8), 32'd0);
        check("reset out_data", 32'(out_data8), 32'd0);
        check("reset busy", 32'(busy8), 32'd0);
        nreset = 1'b1;
        @(negedge clk);

        // 0xA5 into an all-zero chain reads back 0x00; then 0x3C reads back 0xA5.
        write8(8'hA5, 0, 1'b0, 1'b0, 1'b0);
        check("second readback is A5", 32'(chain8), 32'h0000_00A5);
        write8(8'h3C, 5, 1'b0, 1'b0, 1'b0);
        // Requests during SHIFT/UPDATE and at the DONE handshake are ignored.
        write8(8'h5A, 1, 1'b1, 1'b0, 1'b1);
        // Reset in the 4th shift cycle, then a normal write.
        write8(8'h96, 0, 1'b0, 1'b1, 1'b0);
        write8(8'hC3, 2, 1'b0, 1'b0, 1'b0);

        // DW=2 boundary: 2'b10 -> chain_d 0 then 1.
        bq2.push_back(1'b0);
        bq2.push_back(1'b1);
        rq2.push_back({chain2[0], chain2[1]});
        check("dw2 in_ready", 32'(in_ready2), 32'd1);
        in_valid2 = 1'b1;
        in_data2  = 2'b10;
        @(negedge clk);                       // T+1
        in_valid2 = 1'b0;
        check("dw2 chain_en T+1", 32'(chain_en2), 32'd1);
        @(negedge clk);                       // T+2
        check("dw2 chain_en T+2", 32'(chain_en2), 32'd1);
        @(negedge clk);                       // T+3
        check("dw2 chain_en T+3", 32'(chain_en2), 32'd0);
        check("dw2 update T+3", 32'(update2), 32'd1);
        @(negedge clk);                       // T+4
        check("dw2 out_valid T+4", 32'(out_valid2), 32'd1);
        check("dw2 out_data", 32'(out_data2), 32'd0);
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        check("dw2 idle", 32'(in_ready2), 32'd1);
        check("dw2 chain contents", 32'(chain2), 32'b01);

        repeat (2) @(negedge clk);
        check("readbacks8 all seen", 32'(rq8.size()), 32'd0);
        check("chain bits8 all seen", 32'(bq8.size()), 32'd0);
        check("readbacks2 all seen", 32'(rq2.size()), 32'd0);
        check("chain bits2 all seen", 32'(bq2.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
